// File: rtl/mdu_scheduler.sv
// mdu_scheduler: MULT/DIV sequencer with architectural HI/LO and an ID-stage stall request.
// Latency: MUL_CYCLES / DIV_CYCLES busy cycles after the start edge; MTHI/MTLO land on the next edge.
// Backpressure: stall_md holds an MDU-touching ID instruction while an op is in flight; starts while busy are dropped.
module mdu_scheduler #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        md_use_id,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   pend_hi;
    logic [31:0]   pend_lo;
    logic          pend_ok;

    logic [63:0] a_sx;
    logic [63:0] b_sx;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_div;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_ok;
    logic        last_busy;

    // Signed divide works on magnitudes, so 0x80000000 / -1 yields 0x80000000 rem 0 naturally.
    always_comb begin
        a_sx   = {{32{src_a[31]}}, src_a};
        b_sx   = {{32{src_b[31]}}, src_b};
        prod_s = a_sx * b_sx;
        prod_u = {32'd0, src_a} * {32'd0, src_b};

        a_neg  = (op == OP_DIV) & src_a[31];
        b_neg  = (op == OP_DIV) & src_b[31];
        a_mag  = a_neg ? (32'd0 - src_a) : src_a;
        b_mag  = b_neg ? (32'd0 - src_b) : src_b;
        b_div  = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_div;
        r_mag  = a_mag % b_div;
        quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem    = a_neg ? (32'd0 - r_mag) : r_mag;

        res_ok = 1'b1;
        res_hi = rem;
        res_lo = quo;
        case (op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            default:  res_ok = (src_b != 32'd0);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_ok <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                pend_hi <= res_hi;
                                pend_lo <= res_lo;
                                pend_ok <= res_ok;
                                cnt     <= op[1] ? DIV_LOAD : MUL_LOAD;
                                state   <= ST_BUSY;
                            end
                            OP_MTHI: hi <= src_a;
                            OP_MTLO: lo <= src_a;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= ST_IDLE;
                        if (pend_ok) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                    end
                end
            endcase
        end
    end

    assign busy      = (state == ST_BUSY);
    assign last_busy = busy & (cnt == CNT_ONE);

    // The held instruction reads HI/LO in EX one cycle after release, which is after the
    // commit edge, so ID can be let go during the final busy cycle.
    assign stall_md = md_use_id & ((busy & ~last_busy) | (start & ~op[2]));

endmodule
